// File: rtl/seven_seg_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_mux_n
//  Purpose  : Time-multiplexed driver for NDIG seven-segment digits. Scans the
//             enabled digits round-robin, holding each one lit for REFRESH
//             clock cycles. Each digit shows either a raw segment pattern or
//             the hex decode of a nibble.
//  Ports    : clk        - system clock, all logic on posedge
//             rst        - synchronous active-high reset
//             mode       - 0 = raw patterns from seg_raw, 1 = hex decode of hex_in
//             seg_raw    - 7 bits per digit, bit0 = segment a .. bit6 = g
//             hex_in     - 4 bits per digit
//             dig_en     - per-digit enable; disabled digits are skipped
//             segment    - registered active-high segment bus
//             anode      - registered one-hot (or all-zero) digit select
//             digit_idx  - registered index of the current digit
//             sig        - one-cycle pulse on each digit advance
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_mux_n #(
    parameter int NDIG    = 4,
    parameter int REFRESH = 80000,
    parameter int CBITS   = 17,
    parameter int IBITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [7*NDIG-1:0]   seg_raw,
    input  logic [4*NDIG-1:0]   hex_in,
    input  logic [NDIG-1:0]     dig_en,
    output logic [6:0]          segment,
    output logic [NDIG-1:0]     anode,
    output logic [IBITS-1:0]    digit_idx,
    output logic                sig
);

    localparam logic [CBITS-1:0] c_cnt_last = CBITS'(REFRESH - 1);
    localparam logic [IBITS-1:0] c_idx_last = IBITS'(NDIG - 1);
    localparam logic [NDIG-1:0]  c_one      = {{(NDIG-1){1'b0}}, 1'b1};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CBITS-1:0] r_cnt;
    logic [6:0]       r_segment;
    logic [NDIG-1:0]  r_anode;
    logic [IBITS-1:0] r_idx;
    logic             r_sig;

    logic             w_tick;
    logic             w_any;
    logic             w_hi_found;
    logic [IBITS-1:0] w_hi;
    logic [IBITS-1:0] w_lo;
    logic [IBITS-1:0] w_nxt;
    logic [IBITS-1:0] w_inc;
    logic [6:0]       w_raw;
    logic [3:0]       w_nib;
    logic [6:0]       w_pat;

    assign w_tick = (r_cnt == c_cnt_last);

    // Next-digit search. Scanning from the top down means the last hit is the
    // lowest qualifying index: w_hi is the first enabled digit above the
    // current one, w_lo is the lowest enabled digit overall (the wrap target,
    // which may be the current digit itself when it is the only one enabled).
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (dig_en[k]) begin
                w_any = 1'b1;
                w_lo  = IBITS'(k);
                if (IBITS'(k) > r_idx) begin
                    w_hi_found = 1'b1;
                    w_hi       = IBITS'(k);
                end
            end
        end
        w_nxt = w_hi_found ? w_hi : w_lo;
    end

    // Slice out the selected digit's raw pattern and nibble.
    always_comb begin
        w_raw = '0;
        w_nib = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (IBITS'(k) == w_nxt) begin
                w_raw = seg_raw[7*k +: 7];
                w_nib = hex_in[4*k +: 4];
            end
        end
    end

    assign w_pat = mode ? hex7(w_nib) : w_raw;
    assign w_inc = (r_idx == c_idx_last) ? '0 : r_idx + IBITS'(1);

    // All inputs are only looked at on the tick edge, so the lit digit never
    // changes appearance in the middle of its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sig     <= 1'b0;
            r_idx     <= '0;
            r_anode   <= '0;
            r_segment <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sig <= 1'b1;
            if (!w_any) begin
                // Nothing enabled: keep stepping the index but blank the display.
                r_idx     <= w_inc;
                r_anode   <= '0;
                r_segment <= '0;
            end else begin
                r_idx     <= w_nxt;
                r_anode   <= c_one << w_nxt;
                r_segment <= w_pat;
            end
        end else begin
            r_cnt <= r_cnt + CBITS'(1);
            r_sig <= 1'b0;
        end
    end

    assign segment   = r_segment;
    assign anode     = r_anode;
    assign digit_idx = r_idx;
    assign sig       = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_mux_n
//  Purpose  : Scoreboard bench for seven_seg_mux_n with NDIG=4, REFRESH=4.
//             Stimulus pushes the expected {anode, segment, digit_idx} for each
//             upcoming tick; a monitor pops on every sig pulse, and checks that
//             outputs hold between ticks and are zero under reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_mux_n;

    localparam int NDIG    = 4;
    localparam int REFRESH = 4;
    localparam int CBITS   = 3;
    localparam int IBITS   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic [7*NDIG-1:0] seg_raw = '0;
    logic [4*NDIG-1:0] hex_in = '0;
    logic [NDIG-1:0]   dig_en = '0;
    logic [6:0]        segment;
    logic [NDIG-1:0]   anode;
    logic [IBITS-1:0]  digit_idx;
    logic              sig;

    int n_checks = 0;
    int n_pass   = 0;

    logic [12:0] exp_q[$];   // {anode[3:0], segment[6:0], idx[1:0]}
    logic [12:0] last_out = '0;

    seven_seg_mux_n #(
        .NDIG(NDIG), .REFRESH(REFRESH), .CBITS(CBITS), .IBITS(IBITS)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .seg_raw(seg_raw), .hex_in(hex_in),
        .dig_en(dig_en), .segment(segment), .anode(anode),
        .digit_idx(digit_idx), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_tick(input logic [3:0] an, input logic [6:0] seg, input logic [1:0] idx);
        exp_q.push_back({an, seg, idx});
    endtask

    // Wait for the next sig, with `start` cycles of the slot already elapsed;
    // the pulse must land exactly REFRESH cycles into the slot.
    task automatic wait_tick(input int start);
        int n;
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!sig && n < REFRESH + 4);
        check("tick_spacing", n, REFRESH);
        #1;
    endtask

    // Monitor: reset values, scoreboard pops on sig, hold between ticks.
    always @(negedge clk) begin
        logic [12:0] cur;
        cur = {anode, segment, digit_idx};
        if (rst) begin
            check("reset_outputs", {cur, sig}, 14'h0);
            last_out = '0;
        end else if (sig) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                check("tick_outputs", cur, exp_q.pop_front());
            end
            check("anode_onehot", ($countones(anode) <= 1) ? 1 : 0, 1);
            last_out = cur;
        end else begin
            check("hold_outputs", cur, last_out);
        end
    end

    initial begin
        // Reset, then hex mode with all digits enabled; hex_in digits 3..0 = 3,A,0,5.
        mode   = 1'b1;
        hex_in = 16'h3A05;
        dig_en = 4'hF;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        expect_tick(4'b0010, 7'h3F, 2'd1);
        wait_tick(0);
        expect_tick(4'b0100, 7'h77, 2'd2);
        wait_tick(0);
        expect_tick(4'b1000, 7'h4F, 2'd3);
        wait_tick(0);
        expect_tick(4'b0001, 7'h6D, 2'd0);
        wait_tick(0);

        // Raw mode, only digits 0 and 2 enabled.
        mode    = 1'b0;
        seg_raw = {7'h08, 7'h04, 7'h02, 7'h01};
        dig_en  = 4'b0101;
        for (int r = 0; r < 2; r++) begin
            expect_tick(4'b0100, 7'h04, 2'd2);
            wait_tick(0);
            expect_tick(4'b0001, 7'h01, 2'd0);
            wait_tick(0);
        end

        // Everything disabled: blank display, index keeps stepping.
        dig_en = 4'b0000;
        expect_tick(4'b0000, 7'h00, 2'd1);
        wait_tick(0);
        expect_tick(4'b0000, 7'h00, 2'd2);
        wait_tick(0);

        // Single enabled digit 3: reached, then held on every tick.
        dig_en = 4'b1000;
        expect_tick(4'b1000, 7'h08, 2'd3);
        wait_tick(0);
        expect_tick(4'b1000, 7'h08, 2'd3);
        wait_tick(0);

        // Mid-slot change at cnt=1: segment must stay 08 until the next tick.
        expect_tick(4'b1000, 7'h07, 2'd3);
        @(negedge clk);
        #1;
        mode   = 1'b1;
        hex_in = 16'h7000;
        wait_tick(1);

        // Back to full scan, then reset mid-slot while anode=0100.
        hex_in = 16'h3A05;
        dig_en = 4'hF;
        expect_tick(4'b0001, 7'h6D, 2'd0);
        wait_tick(0);
        expect_tick(4'b0010, 7'h3F, 2'd1);
        wait_tick(0);
        expect_tick(4'b0100, 7'h77, 2'd2);
        wait_tick(0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        expect_tick(4'b0010, 7'h3F, 2'd1);
        wait_tick(0);
        expect_tick(4'b0100, 7'h77, 2'd2);
        wait_tick(0);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net: a stuck simulation still reports and ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
